// File: rtl/dcache_pkg.sv
// Shared types and constants for the data cache miss controller and its tag store.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        UPDATE    = 2'd3
    } dcache_state_e;

    localparam int unsigned NO_LOAD  = 0;
    localparam int unsigned NO_STORE = 0;

    // Tag bits are whatever remains above the index and line offset fields.
    function automatic int unsigned tag_width(input int unsigned address_width,
                                              input int unsigned index_width,
                                              input int unsigned offset_width);
        return address_width - index_width - offset_width;
    endfunction

endpackage

// File: rtl/dcache_tag_store.sv
// Valid/dirty/tag arrays for the direct-mapped data cache: one async read port,
// one line-install write port and one dirty-set port.
module dcache_tag_store
    import dcache_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 5,
    parameter int unsigned TAG_WIDTH   = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   rd_valid,
    output logic                   rd_dirty,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic                   dirty_set_en,
    input  logic [INDEX_WIDTH-1:0] dirty_set_index
);

    localparam int unsigned LINES = 2 ** INDEX_WIDTH;

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;
    logic [TAG_WIDTH-1:0] tag_q [LINES];

    // Installing a line makes it valid and clean; a later store hit dirties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[wr_index] <= 1'b1;
                dirty_q[wr_index] <= 1'b0;
            end
            if (dirty_set_en) begin
                dirty_q[dirty_set_index] <= 1'b1;
            end
        end
    end

    // Tags need no reset: they are never consulted without their valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];

endmodule

// File: rtl/data_cache_miss_controller.sv
// Miss-handling FSM for the direct-mapped write-back, write-allocate data cache.
// Optional hit/miss/writeback counters are built when DCACHE_PERF_COUNTER_EN is defined.
module data_cache_miss_controller
    import dcache_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH     = 32,
    parameter int unsigned LINE_OFFSET_WIDTH = 4,
    parameter int unsigned INDEX_WIDTH       = 5,
    parameter int unsigned D_CACHE_LW_WIDTH  = 3,
    parameter int unsigned D_CACHE_SW_WIDTH  = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD,
    input  logic [D_CACHE_SW_WIDTH-1:0] DATA_CACHE_STORE,
    input  logic [ADDRESS_WIDTH-1:0]    DATA_CACHE_ADDRESS,
    input  logic                        STALL_DATA_CACHE,
    output logic                        DATA_CACHE_READY,
    output logic                        MEM_REQ,
    output logic                        MEM_WE,
    output logic [ADDRESS_WIDTH-1:0]    MEM_ADDRESS,
    input  logic                        MEM_ACK,
    output logic                        WRITEBACK_READ_EN,
    output logic                        REFILL_WRITE_EN
`ifdef DCACHE_PERF_COUNTER_EN
    ,
    output logic [ADDRESS_WIDTH-1:0]    HIT_COUNT,
    output logic [ADDRESS_WIDTH-1:0]    MISS_COUNT,
    output logic [ADDRESS_WIDTH-1:0]    WRITEBACK_COUNT
`endif
);

    localparam int unsigned TAG_WIDTH = tag_width(ADDRESS_WIDTH, INDEX_WIDTH, LINE_OFFSET_WIDTH);

    dcache_state_e state_q, state_d;

    logic [ADDRESS_WIDTH-1:0] miss_address_reg;
    logic [TAG_WIDTH-1:0]     req_tag, miss_tag, rd_tag;
    logic [INDEX_WIDTH-1:0]   req_index, miss_index, rd_index;
    logic                     rd_valid, rd_dirty;
    logic                     is_load, is_store, request, hit;
    logic                     ready_c, miss_start, dirty_set, tag_write;
    logic                     unused_offset;

    assign req_tag    = DATA_CACHE_ADDRESS[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    assign req_index  = DATA_CACHE_ADDRESS[LINE_OFFSET_WIDTH +: INDEX_WIDTH];
    assign miss_tag   = miss_address_reg[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    assign miss_index = miss_address_reg[LINE_OFFSET_WIDTH +: INDEX_WIDTH];

    // Byte offset within the line is irrelevant to tag bookkeeping.
    assign unused_offset = ^DATA_CACHE_ADDRESS[LINE_OFFSET_WIDTH-1:0];

    assign is_load  = DATA_CACHE_LOAD  != D_CACHE_LW_WIDTH'(NO_LOAD);
    assign is_store = DATA_CACHE_STORE != D_CACHE_SW_WIDTH'(NO_STORE);
    assign request  = is_load | is_store;

    // The read port follows the live access in IDLE and the missing line otherwise.
    assign rd_index = (state_q == IDLE) ? req_index : miss_index;
    assign hit      = rd_valid & (rd_tag == req_tag);

    dcache_tag_store #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_tag_store (
        .clk             (CLK),
        .rst             (RST),
        .rd_index        (rd_index),
        .rd_valid        (rd_valid),
        .rd_dirty        (rd_dirty),
        .rd_tag          (rd_tag),
        .wr_en           (tag_write),
        .wr_index        (miss_index),
        .wr_tag          (miss_tag),
        .dirty_set_en    (dirty_set),
        .dirty_set_index (req_index)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q          <= IDLE;
            miss_address_reg <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                miss_address_reg <= {req_tag, req_index, {LINE_OFFSET_WIDTH{1'b0}}};
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        ready_c           = 1'b0;
        miss_start        = 1'b0;
        dirty_set         = 1'b0;
        tag_write         = 1'b0;
        MEM_REQ           = 1'b0;
        MEM_WE            = 1'b0;
        MEM_ADDRESS       = '0;
        WRITEBACK_READ_EN = 1'b0;
        REFILL_WRITE_EN   = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = !request || hit;
                if (request && !STALL_DATA_CACHE) begin
                    if (hit) begin
                        dirty_set = is_store;
                    end else begin
                        miss_start = 1'b1;
                        state_d    = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                MEM_REQ           = 1'b1;
                MEM_WE            = 1'b1;
                WRITEBACK_READ_EN = 1'b1;
                MEM_ADDRESS       = {rd_tag, miss_index, {LINE_OFFSET_WIDTH{1'b0}}};
                if (MEM_ACK) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                MEM_REQ         = 1'b1;
                MEM_ADDRESS     = miss_address_reg;
                REFILL_WRITE_EN = MEM_ACK;
                if (MEM_ACK) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                tag_write = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign DATA_CACHE_READY = ready_c & ~RST;

`ifdef DCACHE_PERF_COUNTER_EN
    logic hit_event, writeback_start;

    assign hit_event       = (state_q == IDLE) && request && hit && !STALL_DATA_CACHE;
    assign writeback_start = miss_start && (state_d == WRITEBACK);

    // Saturating event counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            HIT_COUNT       <= '0;
            MISS_COUNT      <= '0;
            WRITEBACK_COUNT <= '0;
        end else begin
            if (hit_event && (HIT_COUNT != '1)) begin
                HIT_COUNT <= HIT_COUNT + ADDRESS_WIDTH'(1);
            end
            if (miss_start && (MISS_COUNT != '1)) begin
                MISS_COUNT <= MISS_COUNT + ADDRESS_WIDTH'(1);
            end
            if (writeback_start && (WRITEBACK_COUNT != '1)) begin
                WRITEBACK_COUNT <= WRITEBACK_COUNT + ADDRESS_WIDTH'(1);
            end
        end
    end
`endif

endmodule
